hpdcache_mem_read_credit_arbiter: RTL and testbench

Credit-limited round-robin arbiter for the HPDcache memory read channel. It sits between N read requesters (I$ miss, I$ uncached, D$ miss, D$ uncached) and the single hpdcache-to-AXI read adapter. It bounds outstanding transactions per requester and in total, and records which requester owns each in-flight transaction ID. It uses that ownership table to route read responses back, so a static ID-to-requester map is no longer needed.

---
 rtl/hpdcache_mem_read_credit_arbiter_pkg.sv | 33 +++
 rtl/hpdcache_mem_read_credit_arbiter_rr_pick.sv | 31 +++
 rtl/hpdcache_mem_read_credit_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_hpdcache_mem_read_credit_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_mem_read_credit_arbiter_pkg.sv
// Shared types and helpers for the HPDcache memory read credit arbiter:
// in-flight table entry, default request/response payloads, counter sizing.
package hpdcache_mem_arb_pkg;

    localparam int unsigned MEM_ID_W  = 4;
    // Widest requester index the table entry can carry; the arbiter narrows it to clog2(N).
    localparam int unsigned SRC_W_MAX = 4;

    typedef logic [SRC_W_MAX-1:0] src_idx_t;

    typedef struct packed {
        logic     valid;
        src_idx_t src;
    } rt_entry_t;

    typedef struct packed {
        logic [31:0]         mem_req_addr;
        logic [7:0]          mem_req_len;
        logic [MEM_ID_W-1:0] mem_req_id;
    } hpdcache_mem_req_t;

    typedef struct packed {
        logic [31:0]         mem_resp_r_data;
        logic                mem_resp_r_last;
        logic [MEM_ID_W-1:0] mem_resp_r_id;
    } hpdcache_mem_resp_r_t;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hpdcache_mem_read_credit_arbiter_rr_pick.sv
// Rotating-priority picker: grants the first eligible index strictly after ptr,
// wrapping modulo N. Purely combinational.
module hpdcache_rr_pick #(
    parameter  int unsigned N    = 4,
    localparam int unsigned SrcW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    eligible,
    input  logic [SrcW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [SrcW-1:0] idx,
    output logic            valid
);

    logic [SrcW-1:0] pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            pos = SrcW'((32'(ptr) + k) % N);
            if (!valid && eligible[pos]) begin
                valid    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/hpdcache_mem_read_credit_arbiter.sv
// Credit-limited round-robin arbiter for the HPDcache memory read channel; tracks
// the owner of every in-flight ID and routes responses back through that table.
module hpdcache_mem_read_credit_arbiter
    import hpdcache_mem_arb_pkg::*;
#(
    parameter  int unsigned N         = 4,
    parameter  int unsigned IdWidth   = 4,
    parameter  int unsigned MaxPerReq = 4,
    parameter  int unsigned MaxTotal  = 8,
    parameter  type         req_t     = hpdcache_mem_req_t,
    parameter  type         resp_t    = hpdcache_mem_resp_r_t,
    localparam int unsigned SrcW      = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned TotW      = cnt_width(MaxTotal)
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic [N-1:0]      req_valid_i,
    output logic [N-1:0]      req_ready_o,
    input  req_t              req_i [N],

    output logic              req_valid_o,
    input  logic              req_ready_i,
    output req_t              req_o,
    output logic [SrcW-1:0]   req_src_o,

    input  logic              resp_valid_i,
    output logic              resp_ready_o,
    input  resp_t             resp_i,

    output logic [N-1:0]      resp_valid_o,
    input  logic [N-1:0]      resp_ready_i,
    output resp_t             resp_o [N],

    output logic [TotW-1:0]   outstanding_o,
    output logic              unmapped_resp_o
);

    typedef logic [SrcW-1:0] src_t;

    localparam int unsigned Depth = 2 ** IdWidth;
    localparam int unsigned CntW  = cnt_width(MaxPerReq);

    rt_entry_t       tbl_q [Depth];
    logic [CntW-1:0] cnt_q [N];
    logic [TotW-1:0] total_q;
    src_t            ptr_q;
    src_t            lock_src_q;
    logic            lock_q;
    logic            unmapped_q;

    logic [IdWidth-1:0] req_id [N];
    logic [N-1:0]       eligible;
    logic [N-1:0]       pick_gnt;
    src_t               pick_idx;
    logic               pick_valid;

    src_t               sel;
    logic [N-1:0]       sel_oh;
    logic               gnt_hs;
    logic [IdWidth-1:0] gnt_id;

    logic [IdWidth-1:0] resp_id;
    rt_entry_t          resp_entry;
    src_t               resp_src;
    logic               resp_mapped;
    logic               resp_hs;
    logic               retire;
    logic [N-1:0]       dec_oh;

    // The table is read from registered state only, so an ID retiring this
    // cycle cannot be re-granted until the next one.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_id[i]   = IdWidth'(req_i[i].mem_req_id);
            eligible[i] = req_valid_i[i]
                       && (cnt_q[i] < CntW'(MaxPerReq))
                       && (total_q < TotW'(MaxTotal))
                       && !tbl_q[req_id[i]].valid;
        end
    end

    hpdcache_rr_pick #(
        .N (N)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .gnt      (pick_gnt),
        .idx      (pick_idx),
        .valid    (pick_valid)
    );

    assign sel         = lock_q ? lock_src_q : pick_idx;
    assign sel_oh      = lock_q ? ({{(N-1){1'b0}}, 1'b1} << lock_src_q) : pick_gnt;
    assign req_valid_o = !rst_i && (lock_q || pick_valid);
    assign gnt_hs      = req_valid_o && req_ready_i;
    assign req_ready_o = gnt_hs ? sel_oh : '0;
    assign req_src_o   = req_valid_o ? sel : '0;
    assign req_o       = req_valid_o ? req_i[sel] : '0;
    assign gnt_id      = req_id[sel];

    assign resp_id     = IdWidth'(resp_i.mem_resp_r_id);
    assign resp_entry  = tbl_q[resp_id];
    assign resp_src    = src_t'(resp_entry.src);
    assign resp_mapped = resp_entry.valid;

    // Unowned IDs are drained immediately so a stray beat can never stall the channel.
    always_comb begin
        resp_valid_o = '0;
        resp_ready_o = 1'b0;
        if (!rst_i) begin
            if (resp_mapped) begin
                resp_valid_o[resp_src] = resp_valid_i;
                resp_ready_o           = resp_ready_i[resp_src];
            end else begin
                resp_ready_o = resp_valid_i;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            resp_o[i] = rst_i ? '0 : resp_i;
        end
    end

    assign resp_hs = !rst_i && resp_valid_i && resp_mapped && resp_ready_i[resp_src];
    assign retire  = resp_hs && resp_i.mem_resp_r_last;
    assign dec_oh  = retire ? ({{(N-1){1'b0}}, 1'b1} << resp_src) : '0;

    assign outstanding_o   = total_q;
    assign unmapped_resp_o = unmapped_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int d = 0; d < Depth; d++) begin
                tbl_q[d] <= '0;
            end
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
            total_q    <= '0;
            ptr_q      <= '0;
            lock_src_q <= '0;
            lock_q     <= 1'b0;
            unmapped_q <= 1'b0;
        end else begin
            unmapped_q <= resp_valid_i && !resp_mapped;

            if (gnt_hs) begin
                lock_q         <= 1'b0;
                ptr_q          <= sel;
                tbl_q[gnt_id]  <= '{valid: 1'b1, src: src_idx_t'(sel)};
            end else if (req_valid_o) begin
                lock_q     <= 1'b1;
                lock_src_q <= sel;
            end

            // Grant and retire never address the same entry: a valid entry blocks its ID.
            if (retire) begin
                tbl_q[resp_id].valid <= 1'b0;
            end

            for (int i = 0; i < N; i++) begin
                if (req_ready_o[i] && !dec_oh[i]) begin
                    cnt_q[i] <= cnt_q[i] + CntW'(1);
                end else if (dec_oh[i] && !req_ready_o[i]) begin
                    cnt_q[i] <= cnt_q[i] - CntW'(1);
                end
            end

            if (gnt_hs && !retire) begin
                total_q <= total_q + TotW'(1);
            end else if (retire && !gnt_hs) begin
                total_q <= total_q - TotW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hpdcache_mem_read_credit_arbiter.sv
// Self-checking bench for the memory read credit arbiter: response-lookup vector
// table plus hand-written multi-cycle sequences, with grant and response scoreboards.
module tb_hpdcache_mem_read_credit_arbiter;
    import hpdcache_mem_arb_pkg::*;

    localparam int unsigned N = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [N-1:0]         req_valid_i;
    logic [N-1:0]         req_ready_o;
    hpdcache_mem_req_t    req_i [N];
    logic                 req_valid_o;
    logic                 req_ready_i;
    hpdcache_mem_req_t    req_o;
    logic [1:0]           req_src_o;
    logic                 resp_valid_i;
    logic                 resp_ready_o;
    hpdcache_mem_resp_r_t resp_i;
    logic [N-1:0]         resp_valid_o;
    logic [N-1:0]         resp_ready_i;
    hpdcache_mem_resp_r_t resp_o [N];
    logic [3:0]           outstanding_o;
    logic                 unmapped_resp_o;

    always #5 clk_i = ~clk_i;

    hpdcache_mem_read_credit_arbiter #(
        .N (4), .IdWidth (4), .MaxPerReq (4), .MaxTotal (8)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_i           (req_i),
        .req_valid_o     (req_valid_o),
        .req_ready_i     (req_ready_i),
        .req_o           (req_o),
        .req_src_o       (req_src_o),
        .resp_valid_i    (resp_valid_i),
        .resp_ready_o    (resp_ready_o),
        .resp_i          (resp_i),
        .resp_valid_o    (resp_valid_o),
        .resp_ready_i    (resp_ready_i),
        .resp_o          (resp_o),
        .outstanding_o   (outstanding_o),
        .unmapped_resp_o (unmapped_resp_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Ownership model and scoreboards
    logic       own_v [16];
    logic [1:0] own_s [16];

    typedef struct packed { logic [1:0] src; logic [3:0] id; } gexp_t;
    typedef struct packed { logic [1:0] port; logic [31:0] data; } rexp_t;
    gexp_t gq [$];
    rexp_t rq [$];
    gexp_t g_m;
    rexp_t r_m;

    typedef struct {
        logic       rv;
        logic [3:0] id;
        logic [3:0] rr;
        logic [3:0] exp_v;
        logic       exp_r;
    } vec_t;
    vec_t vecs [7];

    always @(negedge clk_i) begin
        if (!rst_i && req_valid_o && req_ready_i) begin
            if (gq.size() == 0) begin
                chk("grant_unexpected", 64'(req_src_o), 64'hff);
            end else begin
                g_m = gq.pop_front();
                chk("grant_src", 64'(req_src_o), 64'(g_m.src));
                chk("grant_id", 64'(req_o.mem_req_id), 64'(g_m.id));
                chk("grant_addr", 64'(req_o.mem_req_addr), 64'(req_i[g_m.src].mem_req_addr));
                chk("grant_ready_o", 64'(req_ready_o), 64'(4'b0001 << g_m.src));
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!rst_i && resp_valid_o[k] && resp_ready_i[k]) begin
                if (rq.size() == 0) begin
                    chk("resp_unexpected", 64'(k), 64'hff);
                end else begin
                    r_m = rq.pop_front();
                    chk("resp_port", 64'(k), 64'(r_m.port));
                    chk("resp_data", 64'(resp_o[k].mem_resp_r_data), 64'(r_m.data));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        req_valid_i  = '0;
        req_ready_i  = 1'b0;
        resp_valid_i = 1'b0;
        resp_ready_i = '0;
        resp_i       = '0;
        for (int i = 0; i < N; i++) req_i[i] = '0;
    endtask

    task automatic set_req(input int r, input logic [3:0] id);
        req_i[r].mem_req_addr = $urandom;
        req_i[r].mem_req_len  = 8'd0;
        req_i[r].mem_req_id   = id;
    endtask

    task automatic expect_grant(input logic [1:0] src, input logic [3:0] id);
        gq.push_back({src, id});
        own_v[id] = 1'b1;
        own_s[id] = src;
    endtask

    task automatic drive_resp(input logic rv, input logic [3:0] id, input logic last,
                              input logic [3:0] rr);
        resp_valid_i           = rv;
        resp_i.mem_resp_r_id   = id;
        resp_i.mem_resp_r_last = last;
        resp_i.mem_resp_r_data = $urandom;
        resp_ready_i           = rr;
        if (rv && own_v[id] && rr[own_s[id]]) rq.push_back({own_s[id], resp_i.mem_resp_r_data});
    endtask

    logic [3:0] rdy_snap;
    logic       prev_unm;
    int         guard;

    initial begin
        for (int i = 0; i < 16; i++) begin own_v[i] = 1'b0; own_s[i] = 2'd0; end
        vecs[0] = '{1'b1, 4'd2, 4'b0100, 4'b0100, 1'b1};
        vecs[1] = '{1'b1, 4'd2, 4'b1011, 4'b0100, 1'b0};
        vecs[2] = '{1'b1, 4'd0, 4'b0001, 4'b0001, 1'b1};
        vecs[3] = '{1'b0, 4'd3, 4'b1000, 4'b0000, 1'b1};
        vecs[4] = '{1'b1, 4'd1, 4'b0000, 4'b0010, 1'b0};
        vecs[5] = '{1'b1, 4'd3, 4'b1111, 4'b1000, 1'b1};
        vecs[6] = '{1'b1, 4'd9, 4'b0000, 4'b0000, 1'b1};

        // Reset
        rst_i = 1'b1;
        idle();
        step();
        @(negedge clk_i);
        chk("rst_req_valid_o", 64'(req_valid_o), 64'd0);
        chk("rst_req_ready_o", 64'(req_ready_o), 64'd0);
        chk("rst_resp_valid_o", 64'(resp_valid_o), 64'd0);
        chk("rst_resp_ready_o", 64'(resp_ready_o), 64'd0);
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("rst_unmapped", 64'(unmapped_resp_o), 64'd0);
        step();
        rst_i = 1'b0;

        // Round-robin from ptr 0: order 1,2,3,0
        for (int i = 0; i < N; i++) set_req(i, 4'(i));
        req_valid_i = 4'b1111;
        req_ready_i = 1'b1;
        expect_grant(2'd1, 4'd1);
        expect_grant(2'd2, 4'd2);
        expect_grant(2'd3, 4'd3);
        expect_grant(2'd0, 4'd0);
        guard = 0;
        while (gq.size() != 0 && guard < 10) begin
            @(negedge clk_i);
            rdy_snap = req_ready_o;
            step();
            req_valid_i = req_valid_i & ~rdy_snap;
            guard++;
        end
        chk("rr_all_granted", 64'(gq.size()), 64'd0);
        gq.delete();
        req_valid_i = '0;
        @(negedge clk_i);
        chk("rr_outstanding", 64'(outstanding_o), 64'd4);
        step();

        // Response lookup vectors (no last beats, table unchanged)
        prev_unm = 1'b0;
        for (int v = 0; v < 7; v++) begin
            drive_resp(vecs[v].rv, vecs[v].id, 1'b0, vecs[v].rr);
            @(negedge clk_i);
            chk($sformatf("vec%0d_resp_valid_o", v), 64'(resp_valid_o), 64'(vecs[v].exp_v));
            chk($sformatf("vec%0d_resp_ready_o", v), 64'(resp_ready_o), 64'(vecs[v].exp_r));
            chk($sformatf("vec%0d_unmapped", v), 64'(unmapped_resp_o), 64'(prev_unm));
            prev_unm = vecs[v].rv && !own_v[vecs[v].id];
            step();
        end
        idle();
        @(negedge clk_i);
        chk("unmapped_pulse", 64'(unmapped_resp_o), 64'(prev_unm));
        step();
        @(negedge clk_i);
        chk("unmapped_one_cycle", 64'(unmapped_resp_o), 64'd0);
        chk("unmapped_outstanding", 64'(outstanding_o), 64'd4);
        step();

        // Two-beat response for ID 2 (owner 2), ready 1,0,1
        drive_resp(1'b1, 4'd2, 1'b0, 4'b0100);
        @(negedge clk_i);
        chk("beat0_valid_o", 64'(resp_valid_o), 64'b0100);
        step();
        drive_resp(1'b1, 4'd2, 1'b1, 4'b0000);
        @(negedge clk_i);
        chk("beat1_stall_ready_o", 64'(resp_ready_o), 64'd0);
        chk("beat1_stall_outstanding", 64'(outstanding_o), 64'd4);
        step();
        drive_resp(1'b1, 4'd2, 1'b1, 4'b0100);
        @(negedge clk_i);
        chk("beat1_valid_o", 64'(resp_valid_o), 64'b0100);
        chk("beat1_outstanding", 64'(outstanding_o), 64'd4);
        step();
        own_v[2] = 1'b0;
        idle();
        @(negedge clk_i);
        chk("after_last_outstanding", 64'(outstanding_o), 64'd3);
        step();

        // Per-requester limit: requester 2 issues IDs 4..8
        req_ready_i = 1'b1;
        req_valid_i = 4'b0100;
        for (int id = 4; id < 8; id++) begin
            set_req(2, 4'(id));
            expect_grant(2'd2, 4'(id));
            @(negedge clk_i);
            step();
        end
        set_req(2, 4'd8);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            chk("limit_req_valid_o", 64'(req_valid_o), 64'd0);
            chk("limit_req_ready_o", 64'(req_ready_o), 64'd0);
            chk("limit_outstanding", 64'(outstanding_o), 64'd7);
            step();
        end
        drive_resp(1'b1, 4'd4, 1'b1, 4'b0100);
        @(negedge clk_i);
        chk("limit_retire_cycle_blocked", 64'(req_valid_o), 64'd0);
        step();
        own_v[4] = 1'b0;
        resp_valid_i = 1'b0;
        resp_ready_i = '0;
        expect_grant(2'd2, 4'd8);
        @(negedge clk_i);
        chk("limit_released", 64'(req_valid_o), 64'd1);
        chk("limit_released_outstanding", 64'(outstanding_o), 64'd6);
        step();
        req_valid_i = '0;
        @(negedge clk_i);
        chk("limit_final_outstanding", 64'(outstanding_o), 64'd7);
        step();

        // Lock: grant to requester 1 held while requester 0 competes
        req_ready_i = 1'b0;
        set_req(1, 4'd10);
        req_valid_i = 4'b0010;
        @(negedge clk_i);
        chk("lock_first_src", 64'(req_src_o), 64'd1);
        step();
        set_req(0, 4'd11);
        req_valid_i = 4'b0011;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            chk("lock_held_src", 64'(req_src_o), 64'd1);
            chk("lock_held_valid", 64'(req_valid_o), 64'd1);
            chk("lock_no_ready", 64'(req_ready_o), 64'd0);
            step();
        end
        req_ready_i = 1'b1;
        expect_grant(2'd1, 4'd10);
        @(negedge clk_i);
        step();
        req_valid_i = 4'b0001;
        @(negedge clk_i);
        chk("total_limit_outstanding", 64'(outstanding_o), 64'd8);
        chk("total_limit_blocked", 64'(req_valid_o), 64'd0);
        step();
        req_valid_i = '0;

        // ID collision: requester 3 asks for ID 5 while it is owned by requester 2
        drive_resp(1'b1, 4'd0, 1'b1, 4'b0001);
        @(negedge clk_i);
        step();
        own_v[0] = 1'b0;
        resp_valid_i = 1'b0;
        resp_ready_i = '0;
        set_req(3, 4'd5);
        req_valid_i = 4'b1000;
        @(negedge clk_i);
        chk("collision_blocked", 64'(req_valid_o), 64'd0);
        chk("collision_outstanding", 64'(outstanding_o), 64'd7);
        step();
        drive_resp(1'b1, 4'd5, 1'b1, 4'b0100);
        @(negedge clk_i);
        chk("collision_retire_cycle_blocked", 64'(req_valid_o), 64'd0);
        step();
        own_v[5] = 1'b0;
        resp_valid_i = 1'b0;
        resp_ready_i = '0;
        expect_grant(2'd3, 4'd5);
        @(negedge clk_i);
        chk("collision_granted_valid", 64'(req_valid_o), 64'd1);
        chk("collision_granted_outstanding", 64'(outstanding_o), 64'd6);
        step();
        req_valid_i = '0;
        @(negedge clk_i);
        chk("collision_final_outstanding", 64'(outstanding_o), 64'd7);
        step();

        // Grant (ID 12) and retire (ID 3) in the same cycle: total unchanged
        set_req(0, 4'd12);
        req_valid_i = 4'b0001;
        expect_grant(2'd0, 4'd12);
        drive_resp(1'b1, 4'd3, 1'b1, 4'b1000);
        @(negedge clk_i);
        step();
        own_v[3] = 1'b0;
        idle();
        @(negedge clk_i);
        chk("net_zero_outstanding", 64'(outstanding_o), 64'd7);
        chk("net_zero_unmapped", 64'(unmapped_resp_o), 64'd0);
        step();

        @(negedge clk_i);
        chk("grant_queue_empty", 64'(gq.size()), 64'd0);
        chk("resp_queue_empty", 64'(rq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
